// File: rtl/cmul_accum_pkg.sv
// cmul_accum shared types and defaults.
// Build option: define CMUL_ACCUM_SAT_EN for saturating output narrowing.
package cmul_accum_pkg;

  localparam int IN_W    = 32;
  localparam int ACC_W   = 48;
  localparam int OUT_W   = 16;
  localparam int LEN_W   = 16;
  localparam int SHIFT_W = 6;

  // Largest useful shift for the default accumulator width.
  localparam int SHIFT_CLAMP = ACC_W - 1;

  typedef enum logic {
    ACC,
    HOLD
  } state_e;

endpackage

// File: rtl/cmul_round_sat.sv
// Round-half-up, arithmetic shift and narrow of one accumulator component.
// CMUL_ACCUM_SAT_EN selects saturation; otherwise the result wraps.
import cmul_accum_pkg::*;

module cmul_round_sat #(
  parameter int ACC_WIDTH = ACC_W,
  parameter int OUT_WIDTH = OUT_W,
  parameter int SH_MAX    = SHIFT_CLAMP
) (
  input  logic signed [ACC_WIDTH-1:0] i_sum,
  input  logic [SHIFT_W-1:0]          i_shift,
  output logic [OUT_WIDTH-1:0]        o_val
);

  logic [SHIFT_W-1:0]        w_sh;
  logic signed [ACC_WIDTH:0] w_ext;
  logic signed [ACC_WIDTH:0] w_bias;
  logic signed [ACC_WIDTH:0] w_sum;
  logic signed [ACC_WIDTH:0] w_r;

  assign w_sh = (int'(i_shift) > SH_MAX) ? SHIFT_W'(SH_MAX) : i_shift;

  // One extra bit keeps the rounding bias from overflowing.
  assign w_ext  = {i_sum[ACC_WIDTH-1], i_sum};
  assign w_bias = (w_sh == '0) ? '0 :
                  {{ACC_WIDTH{1'b0}}, 1'b1} << (w_sh - 1'b1);
  assign w_sum  = w_ext + w_bias;
  assign w_r    = w_sum >>> w_sh;

`ifdef CMUL_ACCUM_SAT_EN
  localparam logic signed [ACC_WIDTH:0] MAXV =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    o_val = w_r[OUT_WIDTH-1:0];
    if (w_r > MAXV) begin
      o_val = MAXV[OUT_WIDTH-1:0];
    end else if (w_r < MINV) begin
      o_val = MINV[OUT_WIDTH-1:0];
    end
  end
`else
  logic w_unused_hi;

  assign w_unused_hi = ^w_r[ACC_WIDTH:OUT_WIDTH];
  assign o_val       = w_r[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/cmul_accum.sv
// Integrate-and-dump of the complex product stream into 16-bit I/Q.
// Narrowing saturates when CMUL_ACCUM_SAT_EN is defined, else wraps.
import cmul_accum_pkg::*;

module cmul_accum #(
  parameter int IN_WIDTH  = IN_W,
  parameter int ACC_WIDTH = ACC_W,
  parameter int OUT_WIDTH = OUT_W,
  parameter int LEN_WIDTH = LEN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*IN_WIDTH-1:0]  i_tdata,
  input  logic                   i_tvalid,
  input  logic                   i_tlast,
  output logic                   i_tready,
  input  logic [LEN_WIDTH-1:0]   len,
  input  logic [SHIFT_W-1:0]     shift,
  output logic [2*OUT_WIDTH-1:0] o_tdata,
  output logic                   o_tvalid,
  output logic                   o_tlast,
  input  logic                   o_tready
);

  state_e                       r_state;
  logic signed [ACC_WIDTH-1:0]  r_acc_i;
  logic signed [ACC_WIDTH-1:0]  r_acc_q;
  logic [LEN_WIDTH-1:0]         r_cnt;
  logic [LEN_WIDTH-1:0]         r_len_q;
  logic [SHIFT_W-1:0]           r_shift_q;
  logic [2*OUT_WIDTH-1:0]       r_data;
  logic                         r_last;

  logic                         w_beat;
  logic                         w_dump;
  logic                         w_cnt0;
  logic [LEN_WIDTH-1:0]         w_len_eff;
  logic [SHIFT_W-1:0]           w_sh_eff;
  logic signed [ACC_WIDTH-1:0]  w_ext_i;
  logic signed [ACC_WIDTH-1:0]  w_ext_q;
  logic signed [ACC_WIDTH-1:0]  w_sum_i;
  logic signed [ACC_WIDTH-1:0]  w_sum_q;
  logic [OUT_WIDTH-1:0]         w_out_i;
  logic [OUT_WIDTH-1:0]         w_out_q;

  assign o_tvalid = (r_state == HOLD);
  assign o_tdata  = r_data;
  assign o_tlast  = r_last;
  assign i_tready = !reset && (!o_tvalid || o_tready);
  assign w_beat   = i_tvalid && i_tready;
  assign w_cnt0   = (r_cnt == '0);

  // The first beat of a period uses the live len/shift it captures.
  assign w_len_eff = !w_cnt0 ? r_len_q :
                     (len == '0) ? LEN_WIDTH'(1) : len;
  assign w_sh_eff  = w_cnt0 ? shift : r_shift_q;
  assign w_dump    = w_beat &&
                     (i_tlast || (r_cnt == w_len_eff - 1'b1));

  assign w_ext_i = {{(ACC_WIDTH-IN_WIDTH){i_tdata[2*IN_WIDTH-1]}},
                    i_tdata[2*IN_WIDTH-1:IN_WIDTH]};
  assign w_ext_q = {{(ACC_WIDTH-IN_WIDTH){i_tdata[IN_WIDTH-1]}},
                    i_tdata[IN_WIDTH-1:0]};
  assign w_sum_i = r_acc_i + w_ext_i;
  assign w_sum_q = r_acc_q + w_ext_q;

  cmul_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SH_MAX    (ACC_WIDTH - 1)
  ) u_rs_i (
    .i_sum   (w_sum_i),
    .i_shift (w_sh_eff),
    .o_val   (w_out_i)
  );

  cmul_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SH_MAX    (ACC_WIDTH - 1)
  ) u_rs_q (
    .i_sum   (w_sum_q),
    .i_shift (w_sh_eff),
    .o_val   (w_out_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ACC;
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      r_cnt     <= '0;
      r_len_q   <= '0;
      r_shift_q <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
    end else begin
      if (w_beat) begin
        if (w_cnt0) begin
          r_len_q   <= w_len_eff;
          r_shift_q <= shift;
        end
        if (w_dump) begin
          r_acc_i <= '0;
          r_acc_q <= '0;
          r_cnt   <= '0;
        end else begin
          r_acc_i <= w_sum_i;
          r_acc_q <= w_sum_q;
          r_cnt   <= r_cnt + 1'b1;
        end
      end
      unique case (r_state)
        ACC: begin
          if (w_dump) begin
            r_data  <= {w_out_i, w_out_q};
            r_last  <= i_tlast;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_dump) begin
            r_data <= {w_out_i, w_out_q};
            r_last <= i_tlast;
          end else if (o_tready) begin
            r_state <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

endmodule
